// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// default timing constants and fixed addresses used by init/arbiter/write/read/refresh.
package sdram_pkg;

  localparam logic [3:0] NOP       = 4'b0111;
  localparam logic [3:0] P_CHARGE  = 4'b0010;
  localparam logic [3:0] AUTO_REF  = 4'b0001;
  localparam logic [3:0] M_REG_SET = 4'b0000;
  localparam logic [3:0] ACTIVE    = 4'b0011;
  localparam logic [3:0] READ      = 4'b0101;
  localparam logic [3:0] WRITE     = 4'b0100;

  localparam int unsigned TRP_CLK  = 2;
  localparam int unsigned TRC_CLK  = 7;
  localparam int unsigned TMRD_CLK = 2;

  // A10 high selects all banks for PRECHARGE
  localparam logic [12:0] ADDR_PALL = 13'h0400;

endpackage

// File: rtl/sdram_auto_ref.sv
// Periodic auto-refresh generator: requests the bus every CNT_REF_MAX cycles once init is done,
// then issues PRECHARGE-all followed by AR_NUM AUTO REFRESH commands.
module sdram_auto_ref #(
  parameter int unsigned CNT_REF_MAX = 750,
  parameter int unsigned TRP_CLK     = sdram_pkg::TRP_CLK,
  parameter int unsigned TRC_CLK     = sdram_pkg::TRC_CLK,
  parameter int unsigned AR_NUM      = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_ba,
  output logic [12:0] aref_addr,
  output logic        aref_end
);

  import sdram_pkg::NOP;
  import sdram_pkg::P_CHARGE;
  import sdram_pkg::AUTO_REF;
  import sdram_pkg::ADDR_PALL;

  localparam int unsigned REF_W    = $clog2(CNT_REF_MAX);
  localparam int unsigned WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int unsigned CLK_W    = $clog2(WAIT_MAX + 1);
  localparam int unsigned AR_W     = $clog2(AR_NUM + 1);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(CNT_REF_MAX - 1);
  localparam logic [CLK_W-1:0] TRP_LAST = CLK_W'(TRP_CLK - 1);
  localparam logic [CLK_W-1:0] TRC_LAST = CLK_W'(TRC_CLK - 1);
  localparam logic [AR_W-1:0]  AR_TOTAL = AR_W'(AR_NUM);

  typedef enum logic [2:0] {
    AREF_IDLE,
    AREF_PCHA,
    AREF_TRP,
    AREF_AR,
    AREF_TRF,
    AREF_END
  } aref_state_t;

  aref_state_t r_state;
  aref_state_t w_state_nxt;

  logic [REF_W-1:0] r_cnt_ref;
  logic [CLK_W-1:0] r_cnt_clk;
  logic [AR_W-1:0]  r_cnt_ar;

  logic             r_req;
  logic             r_end;
  logic [3:0]       r_cmd;
  logic [1:0]       r_ba;
  logic [12:0]      r_addr;

  logic             w_ref_wrap;
  logic             w_grant;
  logic             w_end;
  logic [3:0]       w_cmd;
  logic [1:0]       w_ba;
  logic [12:0]      w_addr;

  assign w_ref_wrap = (r_cnt_ref == REF_LAST);
  assign w_grant    = (r_state == AREF_IDLE) && r_req && aref_en;

  // Free-running interval counter; a refresh does not restart it
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt_ref <= '0;
    end else if (!init_end || w_ref_wrap) begin
      r_cnt_ref <= '0;
    end else begin
      r_cnt_ref <= r_cnt_ref + 1'b1;
    end
  end

  // Grant clears the request; a wrap while already requesting is simply absorbed
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_req <= 1'b0;
    end else if (!init_end || w_grant) begin
      r_req <= 1'b0;
    end else if (w_ref_wrap) begin
      r_req <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= AREF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!init_end) begin
      w_state_nxt = AREF_IDLE;
    end else begin
      case (r_state)
        AREF_IDLE: if (w_grant) w_state_nxt = AREF_PCHA;
        AREF_PCHA: w_state_nxt = AREF_TRP;
        AREF_TRP:  if (r_cnt_clk == TRP_LAST) w_state_nxt = AREF_AR;
        AREF_AR:   w_state_nxt = AREF_TRF;
        AREF_TRF:  if (r_cnt_clk == TRC_LAST)
                     w_state_nxt = (r_cnt_ar < AR_TOTAL) ? AREF_AR : AREF_END;
        AREF_END:  w_state_nxt = AREF_IDLE;
        default:   w_state_nxt = AREF_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt_clk <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == AREF_IDLE)) begin
      r_cnt_clk <= '0;
    end else begin
      r_cnt_clk <= r_cnt_clk + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt_ar <= '0;
    end else if (!init_end || (r_state == AREF_END)) begin
      r_cnt_ar <= '0;
    end else if (r_state == AREF_AR) begin
      r_cnt_ar <= r_cnt_ar + 1'b1;
    end
  end

  // Outputs decode the next state so the registered command lines up with the state itself
  always_comb begin
    w_cmd  = NOP;
    w_ba   = '1;
    w_addr = '1;
    w_end  = 1'b0;
    case (w_state_nxt)
      AREF_PCHA: begin
        w_cmd  = P_CHARGE;
        w_addr = ADDR_PALL;
      end
      AREF_AR:  w_cmd = AUTO_REF;
      AREF_END: w_end = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cmd  <= NOP;
      r_ba   <= '1;
      r_addr <= '1;
      r_end  <= 1'b0;
    end else begin
      r_cmd  <= w_cmd;
      r_ba   <= w_ba;
      r_addr <= w_addr;
      r_end  <= w_end;
    end
  end

  assign aref_req  = r_req;
  assign aref_cmd  = r_cmd;
  assign aref_ba   = r_ba;
  assign aref_addr = r_addr;
  assign aref_end  = r_end;

endmodule

// File: tb/tb_sdram_auto_ref.sv
// Scoreboard bench for sdram_auto_ref: expected command events are queued at grant time
// and matched by a monitor whenever the block drives a non-NOP command or aref_end.
module tb_sdram_auto_ref;
  import sdram_pkg::*;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b0;
  logic        init_end = 1'b0;
  logic        aref_en  = 1'b0;
  logic        aref_req;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        fin;
    bit          chk_ab;
  } ev_t;

  ev_t sb[$];

  sdram_auto_ref #(
    .CNT_REF_MAX(750),
    .TRP_CLK    (2),
    .TRC_CLK    (7),
    .AR_NUM     (2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .init_end (init_end),
    .aref_en  (aref_en),
    .aref_req (aref_req),
    .aref_cmd (aref_cmd),
    .aref_ba  (aref_ba),
    .aref_addr(aref_addr),
    .aref_end (aref_end)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Events relative to accept edge a: PRECHARGE at a, AUTO_REF at a+3 and a+11, end at a+19
  task automatic push_seq(input int a, input int nev);
    ev_t e;
    for (int i = 0; i < nev; i++) begin
      e.ba = 2'b11;
      e.addr = 13'h1FFF;
      e.fin = 1'b0;
      e.chk_ab = 1'b1;
      case (i)
        0: begin e.cyc = a;      e.cmd = P_CHARGE; e.addr = 13'h0400; end
        1: begin e.cyc = a + 3;  e.cmd = AUTO_REF; e.chk_ab = 1'b0; end
        2: begin e.cyc = a + 11; e.cmd = AUTO_REF; e.chk_ab = 1'b0; end
        default: begin e.cyc = a + 19; e.cmd = NOP; e.fin = 1'b1; end
      endcase
      sb.push_back(e);
    end
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (aref_cmd != NOP || aref_end) begin
      if (sb.size() == 0) begin
        check_eq("extra_cmd", 32'({aref_end, aref_cmd}), 32'({1'b0, NOP}));
      end else begin
        ev_t e;
        e = sb.pop_front();
        check_eq("ev_cycle", cyc, e.cyc);
        check_eq("ev_cmd", 32'(aref_cmd), 32'(e.cmd));
        check_eq("ev_end", 32'(aref_end), 32'(e.fin));
        if (e.chk_ab) begin
          check_eq("ev_ba", 32'(aref_ba), 32'(e.ba));
          check_eq("ev_addr", 32'(aref_addr), 32'(e.addr));
        end
      end
    end else begin
      check_eq("nop_ba", 32'(aref_ba), 32'h3);
      check_eq("nop_addr", 32'(aref_addr), 32'h1FFF);
    end
  end

  task automatic wait_req(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge sys_clk);
      #1;
      if (aref_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic grant_seq(input int nev, output int a);
    @(negedge sys_clk);
    aref_en = 1'b1;
    a = cyc + 1;
    push_seq(a, nev);
    @(posedge sys_clk);
    #1;
    aref_en = 1'b0;
    check_eq("req_clr", 32'(aref_req), 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check_eq({tag, "_req"}, 32'(aref_req), 0);
    check_eq({tag, "_end"}, 32'(aref_end), 0);
    check_eq({tag, "_cmd"}, 32'(aref_cmd), 32'(NOP));
    check_eq({tag, "_ba"}, 32'(aref_ba), 32'h3);
    check_eq({tag, "_addr"}, 32'(aref_addr), 32'h1FFF);
  endtask

  initial begin
    int n, a, p, cnt, exp_next;

    repeat (3) @(posedge sys_clk);
    #1;
    check_rst_outs("reset");
    @(negedge sys_clk);
    sys_rst = 1'b1;

    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge sys_clk);
      #1;
      if (aref_req) cnt++;
      if (i == 500) aref_en = 1'b1;
      if (i == 503) aref_en = 1'b0;
    end
    check_eq("req_noinit", cnt, 0);

    @(negedge sys_clk);
    init_end = 1'b1;
    wait_req(800, n);
    check_eq("req_latency", n, 750);
    p = cyc;

    grant_seq(4, a);
    wait_until(a + 6);
    aref_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    aref_en = 1'b0;
    wait_until(a + 24);
    check_eq("seq1_drained", sb.size(), 0);
    aref_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    aref_en = 1'b0;
    check_eq("stray_en_req", 32'(aref_req), 0);

    wait_req(800, n);
    check_eq("req_phase1", cyc, p + 750);

    cnt = 0;
    repeat (1600) begin
      @(posedge sys_clk);
      #1;
      if (!aref_req) cnt++;
    end
    check_eq("req_held", cnt, 0);
    grant_seq(4, a);
    wait_until(a + 22);
    check_eq("two_ar_only", sb.size(), 0);

    exp_next = p + 750 * ((a - p) / 750 + 1);
    wait_req(800, n);
    check_eq("req_phase2", cyc, exp_next);

    grant_seq(2, a);
    wait_until(a + 5);
    @(negedge sys_clk);
    init_end = 1'b0;
    @(posedge sys_clk);
    #1;
    check_rst_outs("abort");
    cnt = 0;
    repeat (20) begin
      @(posedge sys_clk);
      #1;
      if (aref_end || aref_req) cnt++;
    end
    check_eq("abort_quiet", cnt, 0);
    check_eq("abort_sb", sb.size(), 0);
    @(negedge sys_clk);
    init_end = 1'b1;
    wait_req(800, n);
    check_eq("req_reinit", n, 750);

    grant_seq(2, a);
    wait_until(a + 3);
    #2;
    sys_rst = 1'b0;
    #1;
    check_rst_outs("async_rst");
    check_eq("rst_sb", sb.size(), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    wait_req(800, n);
    check_eq("req_after_rst", n, 750);
    grant_seq(4, a);
    wait_until(a + 22);
    check_eq("seq_after_rst", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_auto_ref.md
Name: sdram_auto_ref

Overview:
- Periodic auto-refresh generator for the SDRAM controller.
- Sits directly downstream of the SDRAM initialisation block: it starts counting only after init_end is high.
- Requests bus ownership from the controller arbiter, and on grant issues PRECHARGE-all followed by AR_NUM AUTO REFRESH commands with the tRP/tRC gaps.
- Reports completion to the arbiter, which muxes aref_cmd/aref_ba/aref_addr onto the SDRAM pins.

Parameters:
- CNT_REF_MAX, 750, refresh interval in sys_clk cycles (7.5 us at 100 MHz; 8192 rows / 64 ms with margin).
- TRP_CLK, 2, NOP cycles between PRECHARGE and the first AUTO REFRESH (20 ns).
- TRC_CLK, 7, NOP cycles after each AUTO REFRESH (70 ns).
- AR_NUM, 2, AUTO REFRESH commands per refresh operation.

Ports:
- sys_clk  input  1  100 MHz controller clock.
- sys_rst  input  1  asynchronous, active-low reset.
- init_end  input  1  high once SDRAM initialisation is complete; level, held high.
- aref_en  input  1  arbiter grant; meaningful only while aref_req=1.
- aref_req  output  1  refresh request to arbiter.
- aref_cmd  output  4  {cs_n,ras_n,cas_n,we_n}.
- aref_ba  output  2  bank address.
- aref_addr  output  13  address bus.
- aref_end  output  1  one-cycle pulse, refresh operation finished.

Behaviour:
- Command encodings: NOP=4'b0111, P_CHARGE=4'b0010, AUTO_REF=4'b0001.
- All outputs are registered.
- Reset values: aref_req=0, aref_end=0, aref_cmd=NOP, aref_ba=2'b11, aref_addr=13'h1FFF, state=AREF_IDLE, all counters 0.
- Interval counter cnt_ref:
  - Held at 0 while init_end=0.
  - Otherwise counts 0..CNT_REF_MAX-1 and wraps; free-running, not restarted by a refresh.
  - On the cycle cnt_ref==CNT_REF_MAX-1, aref_req is set on the next edge.
- aref_req clears on the edge at which the grant is accepted.
- A wrap while aref_req is already high is absorbed: the request stays high and only one refresh is serviced.
- Grant acceptance: state==AREF_IDLE and aref_req=1 and aref_en=1. aref_en in any other condition is ignored.
- States:
  - AREF_IDLE → AREF_PCHA on grant acceptance.
  - AREF_PCHA: 1 cycle, cmd=P_CHARGE, ba=2'b11, addr=13'h0400 (A10=1, all banks) → AREF_TRP.
  - AREF_TRP: TRP_CLK cycles of NOP → AREF_AR.
  - AREF_AR: 1 cycle, cmd=AUTO_REF, increments cnt_ar → AREF_TRF.
  - AREF_TRF: TRC_CLK cycles of NOP; then → AREF_AR if cnt_ar<AR_NUM, else → AREF_END.
  - AREF_END: 1 cycle, aref_end=1, cmd=NOP; cnt_ar cleared → AREF_IDLE.
- Outside AREF_PCHA and AREF_AR, aref_cmd=NOP, aref_ba=2'b11, aref_addr=13'h1FFF.
- A single wait counter cnt_clk is cleared on every state change.
- Timing with defaults, grant accepted at edge N:
  - PRECHARGE driven in cycle N+1.
  - AUTO_REF in N+4 and N+12.
  - aref_end in N+20; back in IDLE at N+21.
  - 20 cycles of ownership in total.
- aref_en may drop after acceptance; the sequence always completes once started.
- init_end falling mid-operation (controller re-init):
  - Synchronously abort to AREF_IDLE on the next edge.
  - Outputs return to reset values; cnt_ref and aref_req are cleared; no aref_end pulse.
- sys_rst asserted mid-operation: everything returns to reset values immediately (asynchronous).
- Counter widths:
  - cnt_ref: $clog2(CNT_REF_MAX).
  - cnt_clk: wide enough for max(TRP_CLK,TRC_CLK).
  - cnt_ar: $clog2(AR_NUM+1).

Decomposition:
- Shared package sdram_pkg, also used by the init, arbiter, write and read blocks, holds:
  - command encodings NOP, P_CHARGE, AUTO_REF, M_REG_SET, ACTIVE, READ, WRITE;
  - default timing constants TRP_CLK, TRC_CLK, TMRD_CLK;
  - the precharge-all address 13'h0400.
- State encoding stays local to the module.
- No sub-module; the state machine and the three counters live in one module.

Test Plan:
- Hold init_end=0 for 2000 cycles → aref_req stays 0, aref_cmd=NOP throughout. Raise init_end → aref_req rises exactly 750 cycles later.
- aref_en=1 in the cycle after aref_req rises → PRECHARGE/addr 13'h0400/ba 2'b11 at +1, AUTO_REF at +4 and +12, aref_end single pulse at +20, aref_req low from +1.
- Withhold aref_en for 1600 cycles, spanning two wraps → aref_req stays high; after grant, exactly 2 AUTO_REFs are issued. Next request follows the free-running counter phase.
- Pulse aref_en while aref_req=0, and again mid-sequence → no extra commands, sequence timing unchanged.
- Drop init_end during AREF_TRF → next cycle IDLE, cmd=NOP, aref_req=0, no aref_end. Re-raise → request 750 cycles later.
- Assert sys_rst during AREF_AR, asynchronously between edges → outputs at reset values before the next edge; normal operation resumes after release.
